// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receiver and transmitter.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} rx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Parity bit the transmitter would send for this word; unused upper bits must be 0.
  function automatic logic parity_bit(input logic [8:0] word, input int mode);
    parity_bit = (mode == PAR_ODD) ? ~(^word) : ^word;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Loadable down-counter; tick marks the cycle in which the count expires.
module uart_bit_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             tick
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  // Parks at zero after expiry so an unreloaded timer never ticks again.
  assign tick = (count == WIDTH'(1));

endmodule

// File: rtl/uart_rx_frame.sv
// UART receiver with configurable framing, error flags and a ready/valid holding register.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 serial_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_out_valid,
  input  logic                 data_out_ready,
  output logic                 parity_error,
  output logic                 framing_error,
  output logic                 break_detect,
  output logic                 overrun
);

  localparam int SYMBOL = CLOCK_FREQ / BAUD_RATE;
  localparam int HALF   = SYMBOL / 2;
  localparam int TW     = $clog2(SYMBOL + 1);
  localparam int BW     = $clog2(DATA_BITS + 1);

  localparam logic [TW-1:0] SYMBOL_LD = TW'(SYMBOL);
  localparam logic [TW-1:0] HALF_LD   = TW'(HALF);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
  localparam bit            HAS_PAR   = (PARITY != PAR_NONE);
  localparam logic          LAST_STOP = (STOP_BITS == 2);

  logic                 rx_p0, rx_p1, rx;
  rx_state_t            state;
  logic [BW-1:0]        bit_cnt;
  logic                 stop_cnt;
  logic                 brk_wait;
  logic                 par_acc, frm_acc, stop_fail;
  logic [DATA_BITS-1:0] shreg;
  logic                 tmr_load, tmr_tick;
  logic [TW-1:0]        tmr_value;

  // Synchroniser stage: line idles high, so reset to 1 to avoid a false start.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
    end else begin
      rx_p0 <= serial_in;
      rx_p1 <= rx_p0;
    end
  end
  assign rx = rx_p1;

  assign stop_fail = frm_acc | ~rx;

  always_comb begin
    tmr_load  = 1'b0;
    tmr_value = SYMBOL_LD;
    case (state)
      IDLE:      if (!rx) begin
                   tmr_load  = 1'b1;
                   tmr_value = HALF_LD;
                 end
      START:     tmr_load = tmr_tick && !rx;
      DATA, PAR: tmr_load = tmr_tick;
      STOP:      tmr_load = !brk_wait && tmr_tick && (stop_cnt != LAST_STOP);
      default:   tmr_load = 1'b0;
    endcase
  end

  uart_bit_timer #(.WIDTH(TW)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (tmr_load),
    .load_value (tmr_value),
    .tick       (tmr_tick)
  );

  // Frame FSM and holding register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      bit_cnt        <= '0;
      stop_cnt       <= 1'b0;
      brk_wait       <= 1'b0;
      par_acc        <= 1'b0;
      frm_acc        <= 1'b0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
      parity_error   <= 1'b0;
      framing_error  <= 1'b0;
      break_detect   <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (data_out_valid && data_out_ready) data_out_valid <= 1'b0;

      case (state)
        IDLE: if (!rx) state <= START;
        START: if (tmr_tick) begin
          if (rx) begin
            state <= IDLE;
          end else begin
            state    <= DATA;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            par_acc  <= 1'b0;
            frm_acc  <= 1'b0;
          end
        end
        DATA: if (tmr_tick) begin
          shreg   <= {rx, shreg[DATA_BITS-1:1]};
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == LAST_BIT) state <= HAS_PAR ? PAR : STOP;
        end
        PAR: if (tmr_tick) begin
          par_acc <= rx ^ parity_bit(9'(shreg), PARITY);
          state   <= STOP;
        end
        STOP: if (brk_wait) begin
          // Hold off until the line recovers so a long break yields one word.
          if (rx) begin
            brk_wait <= 1'b0;
            state    <= IDLE;
          end
        end else if (tmr_tick) begin
          if (stop_cnt == LAST_STOP) begin
            if (!data_out_valid || data_out_ready) begin
              data_out       <= shreg;
              data_out_valid <= 1'b1;
              parity_error   <= par_acc;
              framing_error  <= stop_fail;
              break_detect   <= stop_fail && (shreg == '0);
            end else begin
              overrun <= 1'b1;
            end
            if (rx) state <= IDLE;
            else    brk_wait <= 1'b1;
          end else begin
            stop_cnt <= 1'b1;
            frm_acc  <= ~rx;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame: 8N1, 7E1 and 8N2 instances at SYMBOL = 5.
module tb_uart_rx_frame;
  import uart_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       ser  [3];
  logic       rdy  [3];
  logic       vld  [3];
  logic       perr [3];
  logic       ferr [3];
  logic       brk  [3];
  logic       ovr  [3];
  logic [7:0] d0, d2;
  logic [6:0] d1;
  logic [8:0] dmon [3];

  assign dmon[0] = {1'b0, d0};
  assign dmon[1] = {2'b0, d1};
  assign dmon[2] = {1'b0, d2};

  uart_rx_frame #(.CLOCK_FREQ(50_000_000), .BAUD_RATE(10_000_000),
                  .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rst(rst), .serial_in(ser[0]), .data_out(d0), .data_out_valid(vld[0]),
    .data_out_ready(rdy[0]), .parity_error(perr[0]), .framing_error(ferr[0]),
    .break_detect(brk[0]), .overrun(ovr[0]));

  uart_rx_frame #(.CLOCK_FREQ(50_000_000), .BAUD_RATE(10_000_000),
                  .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) u_7e1 (
    .clk(clk), .rst(rst), .serial_in(ser[1]), .data_out(d1), .data_out_valid(vld[1]),
    .data_out_ready(rdy[1]), .parity_error(perr[1]), .framing_error(ferr[1]),
    .break_detect(brk[1]), .overrun(ovr[1]));

  uart_rx_frame #(.CLOCK_FREQ(50_000_000), .BAUD_RATE(10_000_000),
                  .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_8n2 (
    .clk(clk), .rst(rst), .serial_in(ser[2]), .data_out(d2), .data_out_valid(vld[2]),
    .data_out_ready(rdy[2]), .parity_error(perr[2]), .framing_error(ferr[2]),
    .break_detect(brk[2]), .overrun(ovr[2]));

  typedef struct {
    int         inst;
    logic [8:0] d;
    logic       pe;
    logic       fe;
    logic       bk;
    int         cyc;
  } rec_t;

  rec_t words[$];
  rec_t r_mon;
  int   vld_cnt [3];
  int   ovr_cnt [3];
  int   cyc = 0;
  int   start_cyc = 0;
  int   tests = 0;
  int   fails = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every accepted word, valid-high cycles and overrun pulses.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (vld[i] === 1'b1 && rdy[i] === 1'b1) begin
        r_mon.inst = i;
        r_mon.d    = dmon[i];
        r_mon.pe   = perr[i];
        r_mon.fe   = ferr[i];
        r_mon.bk   = brk[i];
        r_mon.cyc  = cyc;
        words.push_back(r_mon);
      end
      if (vld[i] === 1'b1) vld_cnt[i] <= vld_cnt[i] + 1;
      if (ovr[i] === 1'b1) ovr_cnt[i] <= ovr_cnt[i] + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic get(input int idx, output rec_t r);
    if (idx < words.size()) begin
      r = words[idx];
    end else begin
      r.inst = -1; r.d = '1; r.pe = 1'bx; r.fe = 1'bx; r.bk = 1'bx; r.cyc = -1;
    end
  endtask

  // Line bits LSB first: start, data, optional parity, stop bits; idle 1 beyond.
  function automatic logic [15:0] fr(input logic [8:0] d, input int nd, input bit has_p,
                                     input logic p, input int nstop, input logic last_stop);
    logic [15:0] b;
    int idx;
    b = '1;
    b[0] = 1'b0;
    for (int i = 0; i < nd; i++) b[1+i] = d[i];
    idx = 1 + nd;
    if (has_p) begin
      b[idx] = p;
      idx++;
    end
    for (int s = 0; s < nstop; s++) b[idx+s] = (s == nstop - 1) ? last_stop : 1'b1;
    return b;
  endfunction

  task automatic send(input int inst, input logic [15:0] b, input int n);
    start_cyc = cyc;
    for (int i = 0; i < n; i++) begin
      ser[inst] = b[i];
      repeat (5) @(posedge clk);
      #1;
    end
    ser[inst] = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  rec_t r;
  int   base, base2, v0, o0;

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ser[i] = 1'b1;
      rdy[i] = 1'b1;
    end
    idle(3);
    chk("rst_valid", 32'(vld[0]), 32'h0);
    chk("rst_data", 32'(d0), 32'h0);
    chk("rst_flags", 32'({perr[0], ferr[0], brk[0], ovr[0]}), 32'h0);
    rst = 1'b0;
    idle(2);

    // 8N1 0x61, ready high
    base = words.size(); v0 = vld_cnt[0];
    send(0, fr(9'h61, 8, 1'b0, 1'b0, 1, 1'b1), 10);
    idle(5);
    chk("t1_words", 32'(words.size() - base), 32'd1);
    get(base, r);
    chk("t1_data", 32'(r.d), 32'h61);
    chk("t1_flags", 32'({r.pe, r.fe, r.bk}), 32'h0);
    chk("t1_latency", 32'(r.cyc - start_cyc), 32'd50);
    chk("t1_valid_cycles", 32'(vld_cnt[0] - v0), 32'd1);

    // 7E1 0x35: good parity bit 0, then flipped
    base = words.size();
    send(1, fr(9'h35, 7, 1'b1, 1'b0, 1, 1'b1), 10);
    idle(3);
    send(1, fr(9'h35, 7, 1'b1, 1'b1, 1, 1'b1), 10);
    idle(5);
    chk("t2_words", 32'(words.size() - base), 32'd2);
    get(base, r);
    chk("t2a_data", 32'(r.d), 32'h35);
    chk("t2a_parity", 32'(r.pe), 32'h0);
    chk("t2a_framing", 32'(r.fe), 32'h0);
    get(base + 1, r);
    chk("t2b_data", 32'(r.d), 32'h35);
    chk("t2b_parity", 32'(r.pe), 32'h1);

    // 8N2 0xA5 with second stop bit low, then a 20-bit-period break
    base = words.size();
    send(2, fr(9'hA5, 8, 1'b0, 1'b0, 2, 1'b0), 11);
    idle(10);
    chk("t3a_words", 32'(words.size() - base), 32'd1);
    get(base, r);
    chk("t3a_data", 32'(r.d), 32'hA5);
    chk("t3a_framing", 32'(r.fe), 32'h1);
    chk("t3a_break", 32'(r.bk), 32'h0);
    base2 = words.size();
    ser[2] = 1'b0;
    idle(100);
    ser[2] = 1'b1;
    idle(30);
    chk("t3b_words", 32'(words.size() - base2), 32'd1);
    get(base2, r);
    chk("t3b_data", 32'(r.d), 32'h0);
    chk("t3b_break", 32'(r.bk), 32'h1);
    chk("t3b_framing", 32'(r.fe), 32'h1);
    chk("t3b_state", 32'(u_8n2.state), 32'(IDLE));
    base = words.size();
    send(2, fr(9'h5A, 8, 1'b0, 1'b0, 2, 1'b1), 11);
    idle(5);
    chk("t3c_words", 32'(words.size() - base), 32'd1);
    get(base, r);
    chk("t3c_data", 32'(r.d), 32'h5A);
    chk("t3c_flags", 32'({r.pe, r.fe, r.bk}), 32'h0);

    // One-cycle glitch, then 0x3E
    v0 = vld_cnt[0];
    ser[0] = 1'b0;
    idle(1);
    ser[0] = 1'b1;
    idle(10);
    chk("t4_no_valid", 32'(vld_cnt[0] - v0), 32'd0);
    chk("t4_state", 32'(u_8n1.state), 32'(IDLE));
    base = words.size();
    send(0, fr(9'h3E, 8, 1'b0, 1'b0, 1, 1'b1), 10);
    idle(5);
    chk("t4_words", 32'(words.size() - base), 32'd1);
    get(base, r);
    chk("t4_data", 32'(r.d), 32'h3E);
    chk("t4_flags", 32'({r.pe, r.fe, r.bk}), 32'h0);

    // Overrun with ready low, then ready only in the third frame's commit cycle
    rdy[0] = 1'b0;
    base = words.size(); o0 = ovr_cnt[0];
    send(0, fr(9'h31, 8, 1'b0, 1'b0, 1, 1'b1), 10);
    idle(3);
    chk("t5a_valid", 32'(vld[0]), 32'h1);
    chk("t5a_data", 32'(d0), 32'h31);
    send(0, fr(9'h32, 8, 1'b0, 1'b0, 1, 1'b1), 10);
    idle(3);
    chk("t5b_data", 32'(d0), 32'h31);
    chk("t5b_valid", 32'(vld[0]), 32'h1);
    chk("t5b_overrun", 32'(ovr_cnt[0] - o0), 32'd1);
    fork
      send(0, fr(9'h33, 8, 1'b0, 1'b0, 1, 1'b1), 10);
      begin
        repeat (49) @(posedge clk);
        #1 rdy[0] = 1'b1;
        @(posedge clk);
        #1 rdy[0] = 1'b0;
      end
    join
    chk("t5c_data", 32'(d0), 32'h33);
    chk("t5c_valid", 32'(vld[0]), 32'h1);
    chk("t5c_overrun", 32'(ovr_cnt[0] - o0), 32'd1);
    chk("t5c_words", 32'(words.size() - base), 32'd1);
    get(base, r);
    chk("t5c_consumed", 32'(r.d), 32'h31);
    rdy[0] = 1'b1;
    idle(3);
    get(base + 1, r);
    chk("t5d_drained", 32'(r.d), 32'h33);

    // Reset during DATA bit 3 of 0xFF
    base = words.size();
    fork
      send(0, fr(9'hFF, 8, 1'b0, 1'b0, 1, 1'b1), 10);
      begin
        repeat (23) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
      end
    join
    idle(5);
    chk("t6_words", 32'(words.size() - base), 32'd0);
    chk("t6_valid", 32'(vld[0]), 32'h0);
    chk("t6_data", 32'(d0), 32'h0);
    chk("t6_flags", 32'({perr[0], ferr[0], brk[0], ovr[0]}), 32'h0);
    chk("t6_state", 32'(u_8n1.state), 32'(IDLE));
    send(0, fr(9'h0D, 8, 1'b0, 1'b0, 1, 1'b1), 10);
    idle(5);
    chk("t6b_words", 32'(words.size() - base), 32'd1);
    get(base, r);
    chk("t6b_data", 32'(r.d), 32'h0D);
    chk("t6b_flags", 32'({r.pe, r.fe, r.bk}), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
